i2c_access_arbiter: RTL and testbench

I2C_ACCESS_ARBITER -- requirements
Module: i2c_access_arbiter

---
 rtl/i2c_access_arbiter.sv | 132 +++++++++++++
 tb/tb_i2c_access_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_access_arbiter.sv
// Two-port round-robin arbiter in front of a single i2c_control register engine.
// Define I2C_ARB_RETRY_EN to re-issue NACKed transfers up to MAX_RETRY times.
`timescale 1ns/1ps
module i2c_access_arbiter #(
  parameter logic [7:0] DEVICE_ID = 8'h78,
  parameter bit         ADDR_MODE = 1'b1,
  parameter int         MAX_RETRY = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        a_req,
  input  logic        a_rd,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wrdata,
  output logic        a_done,
  output logic        a_nack,
  output logic [7:0]  a_rddata,
  input  logic        b_req,
  input  logic        b_rd,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wrdata,
  output logic        b_done,
  output logic        b_nack,
  output logic [7:0]  b_rddata,
  output logic        busy,
  output logic        i2c_wrreg_req,
  output logic        i2c_rdreg_req,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_wrdata,
  output logic [7:0]  i2c_device_id,
  output logic        i2c_addr_mode,
  output logic [31:0] i2c_dly_cnt_max,
  input  logic        i2c_RW_Done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_rddata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  if (MAX_RETRY < 1 || MAX_RETRY > 7) begin : g_bad_retry
    $error("MAX_RETRY must be in 1..7");
  end

  state_t      state, next_state;
  logic        sel_b, last_b, lat_rd, nack_r, grant_b, retry_go;
  logic [15:0] lat_addr, win_addr;
  logic [7:0]  lat_wrdata;

  assign i2c_device_id   = DEVICE_ID;
  assign i2c_addr_mode   = ADDR_MODE;
  assign i2c_dly_cnt_max = 32'd0;
  assign i2c_addr        = lat_addr;
  assign i2c_wrdata      = lat_wrdata;

  // B wins only when A is idle or A held the previous grant.
  assign grant_b  = b_req & (~a_req | ~last_b);
  assign win_addr = grant_b ? b_addr : a_addr;

`ifdef I2C_ARB_RETRY_EN
  localparam logic [2:0] MAX_R = MAX_RETRY[2:0];
  logic [2:0] retry_cnt;
  assign retry_go = i2c_ack & (retry_cnt < MAX_R);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      retry_cnt <= '0;
    else if (state == S_IDLE)
      retry_cnt <= '0;
    else if (state == S_WAIT && i2c_RW_Done && retry_go)
      retry_cnt <= retry_cnt + 3'd1;
  end
`else
  assign retry_go = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (a_req | b_req) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (i2c_RW_Done) next_state = retry_go ? S_ISSUE : S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    i2c_wrreg_req = (state == S_ISSUE) & ~lat_rd;
    i2c_rdreg_req = (state == S_ISSUE) &  lat_rd;
    a_done        = (state == S_DONE) & ~sel_b;
    b_done        = (state == S_DONE) &  sel_b;
    a_nack        = a_done & nack_r;
    b_nack        = b_done & nack_r;
  end

  // Transfer fields are captured once in IDLE and held through DONE.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sel_b      <= 1'b0;
      last_b     <= 1'b1;
      lat_rd     <= 1'b0;
      lat_addr   <= '0;
      lat_wrdata <= '0;
      nack_r     <= 1'b0;
      a_rddata   <= '0;
      b_rddata   <= '0;
    end else begin
      case (state)
        S_IDLE: if (a_req | b_req) begin
          sel_b      <= grant_b;
          lat_rd     <= grant_b ? b_rd : a_rd;
          lat_addr   <= ADDR_MODE ? win_addr : {8'h00, win_addr[7:0]};
          lat_wrdata <= grant_b ? b_wrdata : a_wrdata;
        end
        S_WAIT: if (i2c_RW_Done && !retry_go) begin
          nack_r <= i2c_ack;
          if (sel_b) b_rddata <= i2c_rddata;
          else       a_rddata <= i2c_rddata;
        end
        S_DONE: last_b <= sel_b;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_access_arbiter.sv
// Directed bench for i2c_access_arbiter: arbitration, read/write, NACK handling, reset mid-transfer.
`timescale 1ns/1ps
module tb_i2c_access_arbiter;

  logic        Clk = 1'b0, Rst = 1'b1;
  logic        a_req = 0, a_rd = 0, b_req = 0, b_rd = 0;
  logic [15:0] a_addr = 0, b_addr = 0;
  logic [7:0]  a_wrdata = 0, b_wrdata = 0;
  logic        a_done, a_nack, b_done, b_nack, busy;
  logic [7:0]  a_rddata, b_rddata;
  logic        i2c_wrreg_req, i2c_rdreg_req, i2c_addr_mode;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_wrdata, i2c_device_id;
  logic [31:0] i2c_dly_cnt_max;
  logic        i2c_RW_Done = 0, i2c_ack = 0;
  logic [7:0]  i2c_rddata = 0;

  int n_chk = 0, n_err = 0;
  int wr_cnt = 0, rd_cnt = 0, viol = 0;

  i2c_access_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .a_req(a_req), .a_rd(a_rd), .a_addr(a_addr), .a_wrdata(a_wrdata),
    .a_done(a_done), .a_nack(a_nack), .a_rddata(a_rddata),
    .b_req(b_req), .b_rd(b_rd), .b_addr(b_addr), .b_wrdata(b_wrdata),
    .b_done(b_done), .b_nack(b_nack), .b_rddata(b_rddata),
    .busy(busy), .i2c_wrreg_req(i2c_wrreg_req), .i2c_rdreg_req(i2c_rdreg_req),
    .i2c_addr(i2c_addr), .i2c_wrdata(i2c_wrdata), .i2c_device_id(i2c_device_id),
    .i2c_addr_mode(i2c_addr_mode), .i2c_dly_cnt_max(i2c_dly_cnt_max),
    .i2c_RW_Done(i2c_RW_Done), .i2c_ack(i2c_ack), .i2c_rddata(i2c_rddata)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (i2c_wrreg_req) wr_cnt++;
    if (i2c_rdreg_req) rd_cnt++;
    if ((i2c_wrreg_req & i2c_rdreg_req) | (a_done & b_done)) viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  // One-cycle completion from the engine; returns after the edge that consumes it.
  task automatic rw_done(input logic ack, input logic [7:0] rd);
    i2c_RW_Done = 1'b1; i2c_ack = ack; i2c_rddata = rd;
    step();
    i2c_RW_Done = 1'b0; i2c_ack = 1'b0;
  endtask

  initial begin
    int base, exp_att;
    repeat (2) @(posedge Clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", {a_done, b_done, a_nack, b_nack}, 0);
    chk("rst_start", {i2c_wrreg_req, i2c_rdreg_req}, 0);
    chk("rst_addr", i2c_addr, 0);
    chk("rst_rddata", {a_rddata, b_rddata}, 0);
    chk("dev_id", i2c_device_id, 8'h78);
    chk("addr_mode", i2c_addr_mode, 1);
    chk("dly_max", i2c_dly_cnt_max, 0);
    Rst = 0;
    step();
    chk("rel_nopulse", {i2c_wrreg_req, i2c_rdreg_req, busy}, 0);

    // Contention right after reset: A first, then B.
    a_req = 1; a_rd = 0; a_addr = 16'h1111; a_wrdata = 8'h11;
    b_req = 1; b_rd = 1; b_addr = 16'h2222;
    step();
    chk("c_a_start", {i2c_wrreg_req, i2c_rdreg_req}, 2'b10);
    chk("c_a_addr", i2c_addr, 16'h1111);
    chk("c_a_wrdata", i2c_wrdata, 8'h11);
    chk("c_busy_iss", busy, 1);
    step();
    chk("c_wait_nopulse", {i2c_wrreg_req, i2c_rdreg_req}, 0);
    step();
    chk("c_busy_wait", busy, 1);
    rw_done(0, 8'h00);
    chk("c_a_done", {a_done, b_done, a_nack}, 3'b100);
    chk("c_busy_done", busy, 1);
    a_req = 0;
    step();
    chk("c_gap", {busy, a_done, i2c_rdreg_req}, 0);
    step();
    chk("c_b_start", {i2c_wrreg_req, i2c_rdreg_req}, 2'b01);
    chk("c_b_addr", i2c_addr, 16'h2222);
    chk("c_busy_b", busy, 1);
    step();
    rw_done(0, 8'hA5);
    chk("c_b_done", {a_done, b_done, b_nack}, 3'b010);
    chk("c_b_rddata", b_rddata, 8'hA5);
    b_req = 0;
    step();
    chk("c_idle", busy, 0);

    // Single A register write.
    a_req = 1; a_rd = 0; a_addr = 16'h3008; a_wrdata = 8'h82;
    step();
    chk("w_start", {i2c_wrreg_req, i2c_rdreg_req}, 2'b10);
    chk("w_addr", i2c_addr, 16'h3008);
    chk("w_data", i2c_wrdata, 8'h82);
    step(); step();
    chk("w_hold_addr", i2c_addr, 16'h3008);
    rw_done(0, 8'h00);
    chk("w_done", {a_done, a_nack, b_done}, 3'b100);
    a_req = 0;
    step();
    chk("w_done_1cyc", a_done, 0);

    // A was granted last, so B wins this contention.
    a_req = 1; a_rd = 0; a_addr = 16'h0001; a_wrdata = 8'h01;
    b_req = 1; b_rd = 1; b_addr = 16'h0002;
    step();
    chk("rr_b_first", {i2c_wrreg_req, i2c_rdreg_req}, 2'b01);
    chk("rr_b_addr", i2c_addr, 16'h0002);
    step();
    rw_done(0, 8'h77);
    chk("rr_b_done", {a_done, b_done}, 2'b01);
    b_req = 0;
    step();
    step();
    chk("rr_a_next", {i2c_wrreg_req, i2c_addr}, {1'b1, 16'h0001});
    step();
    rw_done(0, 8'h00);
    chk("rr_a_done", {a_done, b_done}, 2'b10);
    a_req = 0;
    step();

    // Single B register read.
    b_req = 1; b_rd = 1; b_addr = 16'h300A;
    step();
    chk("r_start", {i2c_wrreg_req, i2c_rdreg_req}, 2'b01);
    chk("r_addr", i2c_addr, 16'h300A);
    step();
    rw_done(0, 8'h56);
    chk("r_done", {b_done, b_nack, a_done}, 3'b100);
    chk("r_rddata", b_rddata, 8'h56);
    b_req = 0;
    i2c_rddata = 8'hEE;
    step();
    chk("r_rddata_hold", b_rddata, 8'h56);

    // Persistent NACK.
`ifdef I2C_ARB_RETRY_EN
    exp_att = 4;
`else
    exp_att = 1;
`endif
    base = wr_cnt;
    a_req = 1; a_rd = 0; a_addr = 16'h0050; a_wrdata = 8'h5A;
    step();
    for (int i = 0; i < exp_att; i++) begin
      chk($sformatf("n_start%0d", i), i2c_wrreg_req, 1);
      step();
      rw_done(1, 8'h00);
    end
    chk("n_done", {a_done, a_nack}, 2'b11);
    chk("n_attempts", wr_cnt - base, exp_att);
    a_req = 0;
    step();
    chk("n_idle", {busy, a_done, a_nack}, 0);

    // Reset while waiting on the engine.
    a_req = 1; a_rd = 1; a_addr = 16'h0033;
    step(); step();
    chk("x_wait", busy, 1);
    Rst = 1;
    #1;
    chk("x_rst_busy", busy, 0);
    chk("x_rst_fields", {i2c_addr, i2c_wrdata}, 0);
    chk("x_rst_rddata", {a_rddata, b_rddata}, 0);
    a_req = 0;
    step();
    Rst = 0;
    base = wr_cnt + rd_cnt;
    step();
    rw_done(0, 8'hFF);
    chk("x_late_done", {a_done, b_done, busy}, 0);
    step();
    chk("x_no_pulse", wr_cnt + rd_cnt - base, 0);
    a_req = 1; a_rd = 1; a_addr = 16'h0042;
    step();
    chk("x_start", {i2c_wrreg_req, i2c_rdreg_req, i2c_addr}, {2'b01, 16'h0042});
    step();
    rw_done(0, 8'h3C);
    chk("x_done", {a_done, a_nack, a_rddata}, {2'b10, 8'h3C});
    a_req = 0;
    step();

    chk("exclusive", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
